morse_playback: RTL and testbench
=================================

# morse_playback

Replays stored morse words from the game RAM as a timed key signal on one output, for the result/demo screen and LED playback. It is the transmit-side counterpart of the player key-capture path: it reads 10-bit words (five 2-bit symbols each) sequentially from the 32x10 RAM and converts dots and dashes into tick-timed on/off intervals. It sits between the top-level state machine and the RAM read port, and shares that port with player2 through the top-level address mux.

## Interface
Parameters:
- ADDR_W, 4, RAM address width actually used.
- DOT_TICKS, 1, key-on ticks for a dot.
- DASH_TICKS, 3, key-on ticks for a dash.
- SYM_GAP, 1, key-off ticks between symbols within a word.
- WORD_GAP, 3, key-off ticks between words; replaces SYM_GAP and does not add to it.

Ports:
- clock  in  1  system clock (CLOCK_50 domain); the block uses this one clock only.
- resetn  in  1  reset, asynchronous and active-low.
- tick  in  1  one-cycle timing enable pulse from the rate divider.
- start  in  1  pulse that begins playback; ignored while busy.
- abort  in  1  synchronous stop; wins over all other events except reset.
- word_count  in  ADDR_W+1  number of words to play; latched on start; values above 2^ADDR_W are clamped to 2^ADDR_W.
- ram_addr  out  ADDR_W  read address, registered.
- ram_rden  out  1  read strobe; high for one cycle per word.
- ram_q  in  10  RAM data, valid in the cycle after ram_rden.
- key_out  out  1  morse key signal; 1 = on.
- sym_out  out  2  symbol currently sounding during ON, otherwise 00.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when all words have been played.

## Operation
- Symbol coding, MSB first in the word, bits [9:8] first: 00 empty, 01 dot, 11 dash, 10 reserved. The reserved code is treated as empty.
- States: IDLE, FETCH, WAIT, SYMBOL, ON, GAP, WGAP, DONE.
- IDLE: on start with word_count=0, go to DONE. On start with word_count≠0, latch the count, clear ram_addr and go to FETCH.
- FETCH: ram_rden=1 with the current ram_addr. Go to WAIT.
- WAIT: latch ram_q into a 10-bit shift register and clear the symbol index. Go to SYMBOL.
- SYMBOL: examine the top two bits of the shift register.
  - Dot or dash: load the timer with DOT_TICKS or DASH_TICKS and go to ON.
  - Empty: shift by two, index+1, no time spent; if this was the last of the 5 symbols, take the end-of-word path.
- ON: key_out=1. Each tick decrements the timer. On the tick that reaches 0: if the symbol is not the last non-empty symbol of the word, load SYM_GAP and go to GAP; otherwise take the end-of-word path.
- GAP: on the terminal tick, shift, index+1, go to SYMBOL.
- End-of-word path: if more words remain, ram_addr+1, load WORD_GAP, go to WGAP; otherwise go to DONE.
- A word that is entirely empty produces no key activity and no WORD_GAP before the next FETCH.
- WGAP: on the terminal tick, go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE. ram_addr holds its last value.
- abort in any state: go to IDLE next edge with key_out=0. No done pulse.
- Reset: state IDLE; key_out, sym_out, busy, done, ram_rden and ram_addr all 0.

## Timing
- Start sampled at edge 0 → FETCH in cycle 1, WAIT in cycle 2, SYMBOL in cycle 3. If the first symbol is non-empty, key_out rises in cycle 4.
- key_out and sym_out are registered, decoded from the next state; no glitches.
- ON lasts from entry until the edge after the Nth tick. Ticks are counted only while in ON, GAP or WGAP; ticks arriving in other states are ignored.
- tick and the terminal count in the same cycle as abort: abort wins.
- start during busy is ignored, including start in the DONE cycle.

## Structure
- morse_pkg holds the SYM_EMPTY/SYM_DOT/SYM_DASH/SYM_RSVD constants and the state encoding. player2 and the translator share the same symbol constants.
- Sub-module morse_tick_timer: load value, tick-enabled down-counter, terminal flag.

## Test plan
- Word 01_11_00_00_00, count=1, tick every 4 clocks → key on 1 tick, off 1 tick, on 3 ticks, then done. ram_rden pulses exactly once at addr 0.
- Two words, 01_00_00_00_00 then 11_00_00_00_00 → on for 1 tick, then 3-tick word gap with no extra symbol gap, then on for 3 ticks; ram_addr goes 0 then 1.
- word_count=0 → done pulse 1 cycle after start, ram_rden never asserted, busy high for 1 cycle only.
- Word with reserved code 10_01_... → 10 skipped silently; first key_out rises in cycle 5 (one extra SYMBOL cycle).
- abort mid-dash → key_out=0 and busy=0 next edge, no done pulse; a new start replays from addr 0.
- resetn low mid-playback → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared morse definitions: symbol codes, playback state encoding and
// small symbol-classification helpers used by the playback engine.
package morse_pkg;

  // Two-bit symbol codes, packed MSB-first into 10-bit words.
  localparam logic [1:0] SYM_EMPTY = 2'b00;
  localparam logic [1:0] SYM_DOT   = 2'b01;
  localparam logic [1:0] SYM_DASH  = 2'b11;
  localparam logic [1:0] SYM_RSVD  = 2'b10;

  localparam int SYMS_PER_WORD = 5;
  localparam int WORD_BITS     = 10;
  localparam int TIMER_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SYMBOL = 3'd3,
    ST_ON     = 3'd4,
    ST_GAP    = 3'd5,
    ST_WGAP   = 3'd6,
    ST_DONE   = 3'd7
  } morse_state_t;

  // True for a symbol that keys the output; reserved counts as empty.
  function automatic logic sym_is_key(input logic [1:0] sym);
    return (sym == SYM_DOT) || (sym == SYM_DASH);
  endfunction

  // True when any of the four trailing symbols of a word keys the output.
  function automatic logic rest_has_key(input logic [7:0] rest);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sym_is_key(rest[2*i +: 2])) begin
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/morse_tick_timer.sv
// Tick-enabled down-counter: loads an interval length and flags the tick
// that brings it to zero. Load has priority over counting.
module morse_tick_timer
  import morse_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick_en,
  output logic         terminal
);

  logic [W-1:0] count_r;

  // The tick that consumes the last remaining count ends the interval.
  assign terminal = tick_en && (count_r <= W'(1));

  // Down-counter register: clear, reload, or decrement on an enabled tick.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (tick_en && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/morse_playback.sv
// Morse playback engine: fetches stored words from the game RAM and plays
// their dots and dashes as a tick-timed key signal.
module morse_playback
  import morse_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DOT_TICKS  = 1,
  parameter int DASH_TICKS = 3,
  parameter int SYM_GAP    = 1,
  parameter int WORD_GAP   = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              tick,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   word_count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  input  logic [9:0]        ram_q,
  output logic              key_out,
  output logic [1:0]        sym_out,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0]   NO_WORDS  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]        LAST_IDX  = 3'(SYMS_PER_WORD - 1);
  localparam logic [TIMER_W-1:0] DOT_LD   = TIMER_W'(DOT_TICKS);
  localparam logic [TIMER_W-1:0] DASH_LD  = TIMER_W'(DASH_TICKS);
  localparam logic [TIMER_W-1:0] SGAP_LD  = TIMER_W'(SYM_GAP);
  localparam logic [TIMER_W-1:0] WGAP_LD  = TIMER_W'(WORD_GAP);

  morse_state_t            state_r;
  morse_state_t            nxt_state_s;
  logic [ADDR_W:0]         words_r;
  logic [ADDR_W:0]         nxt_words_s;
  logic [ADDR_W-1:0]       nxt_addr_s;
  logic [WORD_BITS-1:0]    shreg_r;
  logic [WORD_BITS-1:0]    nxt_shreg_s;
  logic [2:0]              idx_r;
  logic [2:0]              nxt_idx_s;
  logic                    tmr_load_s;
  logic [TIMER_W-1:0]      tmr_val_s;
  logic                    timing_s;
  logic                    tick_en_s;
  logic                    term_s;
  logic [ADDR_W:0]         clamp_s;
  logic                    eow_more_s;
  logic [ADDR_W-1:0]       eow_addr_s;
  logic [ADDR_W:0]         eow_words_s;
  logic [1:0]              cur_sym_s;
  logic [WORD_BITS-1:0]    shifted_s;

  assign cur_sym_s = shreg_r[WORD_BITS-1 -: 2];
  assign shifted_s = {shreg_r[WORD_BITS-3:0], 2'b00};

  // Ticks only advance the timer while an interval is actually running.
  assign timing_s  = (state_r == ST_ON) || (state_r == ST_GAP) || (state_r == ST_WGAP);
  assign tick_en_s = tick && timing_s;

  // Requests beyond the address space play every stored word once.
  always_comb begin
    if (word_count > MAX_WORDS) begin
      clamp_s = MAX_WORDS;
    end else begin
      clamp_s = word_count;
    end
  end

  // End-of-word bookkeeping: advance to the next word if any remain.
  always_comb begin
    if (words_r > ONE_WORD) begin
      eow_more_s  = 1'b1;
      eow_addr_s  = ram_addr + ADDR_ONE;
      eow_words_s = words_r - ONE_WORD;
    end else begin
      eow_more_s  = 1'b0;
      eow_addr_s  = ram_addr;
      eow_words_s = words_r;
    end
  end

  morse_tick_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (abort),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tick_en  (tick_en_s),
    .terminal (term_s)
  );

  // Next-state and datapath decisions; abort overrides everything.
  always_comb begin
    nxt_state_s = state_r;
    nxt_addr_s  = ram_addr;
    nxt_words_s = words_r;
    nxt_shreg_s = shreg_r;
    nxt_idx_s   = idx_r;
    tmr_load_s  = 1'b0;
    tmr_val_s   = {TIMER_W{1'b0}};
    if (abort) begin
      nxt_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (word_count == NO_WORDS)) begin
            nxt_state_s = ST_DONE;
          end else if (start) begin
            nxt_words_s = clamp_s;
            nxt_addr_s  = {ADDR_W{1'b0}};
            nxt_state_s = ST_FETCH;
          end else begin
            nxt_state_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          nxt_state_s = ST_WAIT;
        end
        ST_WAIT: begin
          nxt_shreg_s = ram_q;
          nxt_idx_s   = 3'd0;
          nxt_state_s = ST_SYMBOL;
        end
        ST_SYMBOL: begin
          if (sym_is_key(cur_sym_s)) begin
            tmr_load_s  = 1'b1;
            tmr_val_s   = (cur_sym_s == SYM_DASH) ? DASH_LD : DOT_LD;
            nxt_state_s = ST_ON;
          end else if (idx_r == LAST_IDX) begin
            // Only an all-empty word gets here: skip straight to the next fetch.
            nxt_shreg_s = shifted_s;
            nxt_idx_s   = idx_r + 3'd1;
            if (eow_more_s) begin
              nxt_addr_s  = eow_addr_s;
              nxt_words_s = eow_words_s;
              nxt_state_s = ST_FETCH;
            end else begin
              nxt_state_s = ST_DONE;
            end
          end else begin
            nxt_shreg_s = shifted_s;
            nxt_idx_s   = idx_r + 3'd1;
            nxt_state_s = ST_SYMBOL;
          end
        end
        ST_ON: begin
          if (term_s && rest_has_key(shreg_r[WORD_BITS-3:0])) begin
            tmr_load_s  = 1'b1;
            tmr_val_s   = SGAP_LD;
            nxt_state_s = ST_GAP;
          end else if (term_s && eow_more_s) begin
            // The word gap replaces the symbol gap after the last keyed symbol.
            nxt_addr_s  = eow_addr_s;
            nxt_words_s = eow_words_s;
            tmr_load_s  = 1'b1;
            tmr_val_s   = WGAP_LD;
            nxt_state_s = ST_WGAP;
          end else if (term_s) begin
            nxt_state_s = ST_DONE;
          end else begin
            nxt_state_s = ST_ON;
          end
        end
        ST_GAP: begin
          if (term_s) begin
            nxt_shreg_s = shifted_s;
            nxt_idx_s   = idx_r + 3'd1;
            nxt_state_s = ST_SYMBOL;
          end else begin
            nxt_state_s = ST_GAP;
          end
        end
        ST_WGAP: begin
          if (term_s) begin
            nxt_state_s = ST_FETCH;
          end else begin
            nxt_state_s = ST_WGAP;
          end
        end
        ST_DONE: begin
          nxt_state_s = ST_IDLE;
        end
        default: begin
          nxt_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; outputs are decoded from the next state
  // so they change cleanly on the same edge as the state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      words_r  <= {(ADDR_W+1){1'b0}};
      shreg_r  <= {WORD_BITS{1'b0}};
      idx_r    <= 3'd0;
      ram_addr <= {ADDR_W{1'b0}};
      ram_rden <= 1'b0;
      key_out  <= 1'b0;
      sym_out  <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= nxt_state_s;
      words_r  <= nxt_words_s;
      shreg_r  <= nxt_shreg_s;
      idx_r    <= nxt_idx_s;
      ram_addr <= nxt_addr_s;
      ram_rden <= (nxt_state_s == ST_FETCH);
      key_out  <= (nxt_state_s == ST_ON);
      sym_out  <= (nxt_state_s == ST_ON) ? nxt_shreg_s[WORD_BITS-1 -: 2] : SYM_EMPTY;
      busy     <= (nxt_state_s != ST_IDLE);
      done     <= (nxt_state_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_morse_playback.sv
// Scoreboard bench for morse_playback: expected output events are queued
// with the stimulus, and a negedge monitor turns DUT activity into events
// (read strobes, key-on/key-off intervals in ticks, done, return to idle).
module tb_morse_playback;

  typedef enum int {EV_RDEN, EV_ON, EV_OFF, EV_DONE, EV_IDLE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       a;
    int       b;
    int       lat;
  } ev_t;

  ev_t exp_q[$];
  int  nvec = 0;
  int  nmis = 0;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] word_count = 5'd0;
  logic [3:0] ram_addr;
  logic       ram_rden;
  logic [9:0] ram_q = 10'd0;
  logic       key_out;
  logic [1:0] sym_out;
  logic       busy;
  logic       done;

  logic [9:0] mem [0:15];
  logic       tick_en = 1'b0;
  int         tphase = 0;

  morse_playback dut (
    .clock      (clock),
    .resetn     (resetn),
    .tick       (tick),
    .start      (start),
    .abort      (abort),
    .word_count (word_count),
    .ram_addr   (ram_addr),
    .ram_rden   (ram_rden),
    .ram_q      (ram_q),
    .key_out    (key_out),
    .sym_out    (sym_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM model: data valid the cycle after the strobe.
  always @(posedge clock) begin
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  // Tick every 4 clocks while enabled.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      tphase = (tphase + 1) % 4;
      tick = tick_en && (tphase == 0);
    end
  end

  function automatic void expect_ev(ev_kind_t k, int a, int b, int lat);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.lat = lat;
    exp_q.push_back(e);
  endfunction

  function automatic void got(ev_kind_t k, int a, int b, int lat);
    ev_t e;
    nvec++;
    if (exp_q.size() == 0) begin
      nmis++;
      $display("FAIL unexpected_event: got %s a=%0d b=%0d lat=%0d, required no event", k.name(), a, b, lat);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (e.a >= 0 && e.a != a) || (e.b >= 0 && e.b != b) ||
          (e.lat >= 0 && e.lat != lat)) begin
        nmis++;
        $display("FAIL %s_event: got %s a=%0d b=%0d lat=%0d, required %s a=%0d b=%0d lat=%0d",
                 e.kind.name(), k.name(), a, b, lat, e.kind.name(), e.a, e.b, e.lat);
      end
    end
  endfunction

  // Monitor state
  logic       prev_key = 1'b0;
  logic       prev_busy = 1'b0;
  logic       off_active = 1'b0;
  logic       sym_bad = 1'b0;
  logic       off_bad = 1'b0;
  logic [1:0] sym_cap = 2'b00;
  int         on_ticks = 0;
  int         off_ticks = 0;
  int         on_lat = 0;
  int         since = 0;
  int         ev_since = 0;

  // Monitor: convert sampled DUT outputs into events for the scoreboard.
  always @(negedge clock) begin
    if (!resetn) begin
      prev_key = 1'b0; prev_busy = 1'b0; off_active = 1'b0;
      sym_bad = 1'b0; off_bad = 1'b0; on_ticks = 0; off_ticks = 0;
    end else begin
      if (start && !busy) since = 0; else since++;
      if (done || abort) ev_since = 0; else ev_since++;
      if (ram_rden) got(EV_RDEN, int'(ram_addr), -1, since);
      if (key_out && !prev_key) begin
        if (off_active) got(EV_OFF, off_ticks, -1, -1);
        off_active = 1'b0;
        on_ticks = tick ? 1 : 0;
        sym_cap = sym_out;
        sym_bad = 1'b0;
        on_lat = since;
      end else if (key_out) begin
        if (tick) on_ticks++;
        if (sym_out != sym_cap) sym_bad = 1'b1;
      end else if (prev_key) begin
        got(EV_ON, on_ticks, sym_bad ? 2 : int'(sym_cap), on_lat);
        off_active = 1'b1;
        off_ticks = tick ? 1 : 0;
      end else if (off_active && tick) begin
        off_ticks++;
      end
      if (!key_out && sym_out != 2'b00) off_bad = 1'b1;
      if (done) begin
        got(EV_DONE, -1, -1, since);
        off_active = 1'b0;
      end
      if (prev_busy && !busy) begin
        got(EV_IDLE, ev_since, int'(off_bad), -1);
        off_bad = 1'b0;
        off_active = 1'b0;
      end
      prev_key = key_out;
      prev_busy = busy;
    end
  end

  task automatic play(input logic [4:0] cnt, input int hold);
    @(posedge clock); #1;
    word_count = cnt;
    start = 1'b1;
    repeat (hold) @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !busy) && n < 3000) begin
      @(posedge clock); #2;
      n++;
    end
    if (n >= 3000) begin
      nvec++; nmis++;
      $display("FAIL %s_timeout: got %0d events pending busy=%0d, required 0 pending and idle", name, exp_q.size(), busy);
      exp_q.delete();
    end
    repeat (3) @(posedge clock);
  endtask

  task automatic wait_key(input logic [3:0] addr, input string name);
    int n;
    n = 0;
    while (!(key_out && ram_addr == addr) && n < 500) begin
      @(posedge clock); #2;
      n++;
    end
    if (n >= 500) begin
      nvec++; nmis++;
      $display("FAIL %s_key_wait: got key_out=%0d addr=%0d, required key on at addr %0d", name, key_out, ram_addr, addr);
    end
  endtask

  task automatic check_zero(input string name);
    nvec++;
    if (key_out !== 1'b0 || sym_out !== 2'b00 || busy !== 1'b0 || done !== 1'b0 ||
        ram_rden !== 1'b0 || ram_addr !== 4'd0) begin
      nmis++;
      $display("FAIL %s: got key=%b sym=%b busy=%b done=%b rden=%b addr=%h, required all 0",
               name, key_out, sym_out, busy, done, ram_rden, ram_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 10'd0;
    #3;
    check_zero("reset_state");
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(posedge clock);
    tick_en = 1'b1;

    // Dot, symbol gap, dash in one word.
    mem[0] = 10'b01_11_00_00_00;
    expect_ev(EV_RDEN, 0, -1, 1);
    expect_ev(EV_ON, 1, 1, 4);
    expect_ev(EV_OFF, 1, -1, -1);
    expect_ev(EV_ON, 3, 3, -1);
    expect_ev(EV_DONE, -1, -1, -1);
    expect_ev(EV_IDLE, 1, 0, -1);
    play(5'd1, 1);
    drain("dot_dash");

    // Two words: word gap replaces symbol gap.
    mem[0] = 10'b01_00_00_00_00;
    mem[1] = 10'b11_00_00_00_00;
    expect_ev(EV_RDEN, 0, -1, 1);
    expect_ev(EV_ON, 1, 1, 4);
    expect_ev(EV_RDEN, 1, -1, -1);
    expect_ev(EV_OFF, 3, -1, -1);
    expect_ev(EV_ON, 3, 3, -1);
    expect_ev(EV_DONE, -1, -1, -1);
    expect_ev(EV_IDLE, 1, 0, -1);
    play(5'd2, 1);
    drain("two_words");

    // Zero words; start held into the DONE cycle must be ignored.
    expect_ev(EV_DONE, -1, -1, 1);
    expect_ev(EV_IDLE, 1, 0, -1);
    play(5'd0, 2);
    drain("zero_words");

    // Reserved code skipped silently, costing one SYMBOL cycle.
    mem[0] = 10'b10_01_00_00_00;
    expect_ev(EV_RDEN, 0, -1, 1);
    expect_ev(EV_ON, 1, 1, 5);
    expect_ev(EV_DONE, -1, -1, -1);
    expect_ev(EV_IDLE, 1, 0, -1);
    play(5'd1, 1);
    drain("reserved");

    // Abort during the dash of the second word, then replay from address 0.
    mem[0] = 10'b01_00_00_00_00;
    mem[1] = 10'b11_00_00_00_00;
    expect_ev(EV_RDEN, 0, -1, 1);
    expect_ev(EV_ON, 1, 1, 4);
    expect_ev(EV_RDEN, 1, -1, -1);
    expect_ev(EV_OFF, 3, -1, -1);
    expect_ev(EV_ON, -1, 3, -1);
    expect_ev(EV_IDLE, 1, 0, -1);
    play(5'd2, 1);
    wait_key(4'd1, "abort");
    repeat (2) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    drain("abort");
    expect_ev(EV_RDEN, 0, -1, 1);
    expect_ev(EV_ON, 1, 1, 4);
    expect_ev(EV_DONE, -1, -1, -1);
    expect_ev(EV_IDLE, 1, 0, -1);
    play(5'd1, 1);
    drain("replay");

    // Count above 16 clamps to 16 all-empty words; mid-run start ignored.
    for (int i = 0; i < 16; i++) mem[i] = 10'd0;
    for (int k = 0; k < 16; k++) expect_ev(EV_RDEN, k, -1, 1 + 7 * k);
    expect_ev(EV_DONE, -1, -1, 113);
    expect_ev(EV_IDLE, 1, 0, -1);
    play(5'd31, 1);
    repeat (20) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    drain("clamp");

    // Asynchronous reset in the middle of a dash.
    mem[0] = 10'b11_00_00_00_00;
    expect_ev(EV_RDEN, 0, -1, 1);
    play(5'd1, 1);
    wait_key(4'd0, "async_reset");
    @(posedge clock);
    #3 resetn = 1'b0;
    #1 check_zero("async_reset");
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    drain("after_reset");

    nvec++;
    if (exp_q.size() != 0) begin
      nmis++;
      $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
